// File: rtl/ads_pkg.sv
// Shared definitions for the ADS frame readout block.
// Holds the readout FSM state encoding, the default parameter values and a
// small constant helper used to size counters.
package ads_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WAIT_BUSY,
    S_SHIFT,
    S_OUT,
    S_GAP,
    S_DONE
  } ads_state_e;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned CH_NUM_DEF   = 64;
  localparam int unsigned SCLK_DIV_DEF = 2;
  localparam int unsigned CONV_HI_DEF  = 4;
  localparam int unsigned BUSY_TO_DEF  = 256;
  localparam int unsigned CS_GAP_DEF   = 4;

  function automatic int unsigned max2(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ads_shift_rx.sv
// One serial lane deserialiser: shifts sdo_i in MSB first on each sample
// enable.
//   clk_i    : CLK_100M
//   rst_ni   : async active-low reset
//   smp_en_i : sample strobe (cycle in which ADS_CLK goes high)
//   sdo_i    : serial data from the ADC lane
//   data_o   : current shift register contents
module ads_shift_rx #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              smp_en_i,
  input  logic              sdo_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] sh_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       sh_q <= '0;
    else if (smp_en_i) sh_q <= {sh_q[DATA_W-2:0], sdo_i};
  end

  assign data_o = sh_q;

endmodule

// File: rtl/ads_frame_rdout.sv
// Frame readout controller for a serial ADS-type ADC.
// On FRM_START, runs CH_NUM conversions: CONVST pulse, wait for BUSY to rise
// and fall, clock DATA_W bits out of one or two SDO lanes, present the sample
// on DOUT_*, then hold CS_N high for a gap before the next channel.
//   CLK_100M / CLK_RST     : clock / async active-low reset
//   FRM_START, LANE_MODE   : frame start pulse, lane select (latched at start)
//   ADS_CONVST, ADS_BUSY   : conversion control / status (BUSY asynchronous)
//   ADS_CS_N, ADS_CLK      : serial port chip select / clock (idles high)
//   ADS_SDOA, ADS_SDOB     : serial data lanes
//   DOUT_A/B/CH, DOUT_VALID: deserialised sample, channel, valid pulse
//   FRM_BUSY, FRM_DONE     : frame in progress / end-of-frame pulse
//   BUSY_ERR               : BUSY timeout pulse
module ads_frame_rdout
  import ads_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned CH_NUM   = CH_NUM_DEF,
  parameter int unsigned SCLK_DIV = SCLK_DIV_DEF,
  parameter int unsigned CONV_HI  = CONV_HI_DEF,
  parameter int unsigned BUSY_TO  = BUSY_TO_DEF,
  parameter int unsigned CS_GAP   = CS_GAP_DEF,
  localparam int unsigned CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              CLK_100M,
  input  logic              CLK_RST,
  input  logic              FRM_START,
  input  logic              LANE_MODE,
  output logic              ADS_CONVST,
  input  logic              ADS_BUSY,
  output logic              ADS_CS_N,
  output logic              ADS_CLK,
  input  logic              ADS_SDOA,
  input  logic              ADS_SDOB,
  output logic [DATA_W-1:0] DOUT_A,
  output logic [DATA_W-1:0] DOUT_B,
  output logic [CH_W-1:0]   DOUT_CH,
  output logic              DOUT_VALID,
  output logic              FRM_BUSY,
  output logic              FRM_DONE,
  output logic              BUSY_ERR
);

  localparam int unsigned CNT_W =
    $clog2(max2(max2(SCLK_DIV, CONV_HI), max2(BUSY_TO, CS_GAP)) + 1);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  ads_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              mode_q, mode_d;
  logic              seen_q, seen_d;
  logic              sclk_q, sclk_d;
  logic              err_q, err_d;
  logic [1:0]        bsync_q;
  logic [DATA_W-1:0] dout_a_q, dout_b_q;
  logic [CH_W-1:0]   dout_ch_q;
  logic              vld_q;
  logic              smp_en;
  logic              busy_s;
  logic [DATA_W-1:0] sh_a, sh_b;

  assign busy_s = bsync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    mode_d  = mode_q;
    seen_d  = seen_q;
    sclk_d  = sclk_q;
    err_d   = 1'b0;
    smp_en  = 1'b0;
    case (state_q)
      S_IDLE: if (FRM_START) begin
        state_d = S_CONV;
        ch_d    = '0;
        mode_d  = LANE_MODE;
        cnt_d   = '0;
      end
      S_CONV: if (cnt_q == CNT_W'(CONV_HI - 1)) begin
        state_d = S_WAIT_BUSY;
        cnt_d   = '0;
        seen_d  = 1'b0;
      end else cnt_d = cnt_q + 1'b1;
      // Level-tracked: a BUSY that already rose during CONV still counts.
      S_WAIT_BUSY: begin
        if (seen_q && !busy_s) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
        end else if (cnt_q >= CNT_W'(BUSY_TO - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (busy_s) seen_d = 1'b1;
        end
      end
      // Sample on the low-to-high toggle; the last rising edge leaves the
      // clock high, so it is already idle when SHIFT ends.
      S_SHIFT: if (cnt_q == CNT_W'(SCLK_DIV - 1)) begin
        cnt_d  = '0;
        sclk_d = !sclk_q;
        if (!sclk_q) begin
          smp_en = 1'b1;
          bit_d  = bit_q + 1'b1;
          if (bit_q == BIT_W'(DATA_W - 1)) state_d = S_OUT;
        end
      end else cnt_d = cnt_q + 1'b1;
      S_OUT: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: if (cnt_q == CNT_W'(CS_GAP - 1)) begin
        cnt_d = '0;
        if (ch_q == CH_W'(CH_NUM - 1)) state_d = S_DONE;
        else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_CONV;
        end
      end else cnt_d = cnt_q + 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100M or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      bit_q     <= '0;
      mode_q    <= 1'b0;
      seen_q    <= 1'b0;
      sclk_q    <= 1'b1;
      err_q     <= 1'b0;
      bsync_q   <= '0;
      dout_a_q  <= '0;
      dout_b_q  <= '0;
      dout_ch_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      bit_q   <= bit_d;
      mode_q  <= mode_d;
      seen_q  <= seen_d;
      sclk_q  <= sclk_d;
      err_q   <= err_d;
      bsync_q <= {bsync_q[0], ADS_BUSY};
      vld_q   <= (state_q == S_OUT);
      if (state_q == S_OUT) begin
        dout_a_q  <= sh_a;
        dout_b_q  <= mode_q ? sh_b : '0;
        dout_ch_q <= ch_q;
      end
    end
  end

  ads_shift_rx #(.DATA_W(DATA_W)) u_rx_a (
    .clk_i(CLK_100M), .rst_ni(CLK_RST), .smp_en_i(smp_en), .sdo_i(ADS_SDOA), .data_o(sh_a)
  );
  ads_shift_rx #(.DATA_W(DATA_W)) u_rx_b (
    .clk_i(CLK_100M), .rst_ni(CLK_RST), .smp_en_i(smp_en), .sdo_i(ADS_SDOB), .data_o(sh_b)
  );

  assign ADS_CONVST = (state_q == S_CONV);
  assign ADS_CS_N   = !((state_q == S_SHIFT) || (state_q == S_OUT));
  assign ADS_CLK    = sclk_q;
  assign DOUT_A     = dout_a_q;
  assign DOUT_B     = dout_b_q;
  assign DOUT_CH    = dout_ch_q;
  assign DOUT_VALID = vld_q;
  assign FRM_BUSY   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign FRM_DONE   = (state_q == S_DONE);
  assign BUSY_ERR   = err_q;

endmodule

// File: tb/tb_ads_frame_rdout.sv
`timescale 1ns/1ps
module tb_ads_frame_rdout;
  localparam int DW = 16, CHN = 4, DW2 = 18;

  logic gclk = 1'b0, grst_n = 1'b0;
  always #5 gclk = ~gclk;

  logic frm_start = 0, lane_mode = 0, busy = 0, sdoa = 0, sdob = 0;
  logic convst, cs_n, sclk, dvld, fbusy, fdone, berr;
  logic [DW-1:0] douta, doutb;
  logic [1:0] dch;

  logic frm_start2 = 0, busy2 = 0, sdo2 = 0;
  logic convst2, cs2_n, sclk2, dvld2, fbusy2, fdone2, berr2;
  logic [DW2-1:0] douta2, doutb2;
  logic [0:0] dch2;

  ads_frame_rdout #(.DATA_W(DW), .CH_NUM(CHN), .SCLK_DIV(2), .CONV_HI(4),
                    .BUSY_TO(256), .CS_GAP(4)) dut (
    .CLK_100M(gclk), .CLK_RST(grst_n), .FRM_START(frm_start), .LANE_MODE(lane_mode),
    .ADS_CONVST(convst), .ADS_BUSY(busy), .ADS_CS_N(cs_n), .ADS_CLK(sclk),
    .ADS_SDOA(sdoa), .ADS_SDOB(sdob), .DOUT_A(douta), .DOUT_B(doutb), .DOUT_CH(dch),
    .DOUT_VALID(dvld), .FRM_BUSY(fbusy), .FRM_DONE(fdone), .BUSY_ERR(berr));

  ads_frame_rdout #(.DATA_W(DW2), .CH_NUM(2), .SCLK_DIV(3), .CONV_HI(4),
                    .BUSY_TO(256), .CS_GAP(4)) dut2 (
    .CLK_100M(gclk), .CLK_RST(grst_n), .FRM_START(frm_start2), .LANE_MODE(1'b0),
    .ADS_CONVST(convst2), .ADS_BUSY(busy2), .ADS_CS_N(cs2_n), .ADS_CLK(sclk2),
    .ADS_SDOA(sdo2), .ADS_SDOB(1'b0), .DOUT_A(douta2), .DOUT_B(doutb2), .DOUT_CH(dch2),
    .DOUT_VALID(dvld2), .FRM_BUSY(fbusy2), .FRM_DONE(fdone2), .BUSY_ERR(berr2));

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // ADC model: BUSY pulse per conversion (except skip_ch), SDO bits MSB first
  int conv_cnt = 0, skip_ch = 99, busy_len = 20;
  logic [DW-1:0] word_a[CHN], word_b[CHN];
  logic [DW2-1:0] word2 = 18'h2B3C5;

  always @(posedge convst) begin
    conv_cnt++;
    if (conv_cnt - 1 != skip_ch) begin
      repeat (2) @(posedge gclk); #1 busy = 1;
      repeat (busy_len) @(posedge gclk); #1 busy = 0;
    end
  end

  always @(posedge convst2) begin
    repeat (2) @(posedge gclk); #1 busy2 = 1;
    repeat (12) @(posedge gclk); #1 busy2 = 0;
  end

  // Bit k is presented after k ADS_CLK rising edges in the CS_N low window
  int k1 = 0, k2 = 0, idx;
  logic sclk_p = 1, sclk2_p = 1;
  always @(negedge gclk) begin
    if (cs_n) k1 = 0; else if (sclk && !sclk_p) k1++;
    sclk_p = sclk;
    idx = (conv_cnt > 0 && conv_cnt <= CHN) ? conv_cnt - 1 : 0;
    sdoa = (k1 < DW) ? word_a[idx][DW-1-k1] : 1'b0;
    sdob = (k1 < DW) ? word_b[idx][DW-1-k1] : 1'b0;
    if (cs2_n) k2 = 0; else if (sclk2 && !sclk2_p) k2++;
    sclk2_p = sclk2;
    sdo2 = (k2 < DW2) ? word2[DW2-1-k2] : 1'b0;
  end

  // Scoreboard of expected samples, in channel order
  typedef struct packed { logic [1:0] ch; logic [DW-1:0] a; logic [DW-1:0] b; } exp_t;
  exp_t expq[$];
  exp_t e;
  int n_vld = 0, n_done = 0, n_berr = 0;
  logic [DW-1:0] last_a = '0;

  always @(negedge gclk) begin
    if (!grst_n) last_a = '0;
    else if (dvld) begin
      n_vld++;
      if (expq.size() == 0) chk("unexp_vld", 1, 0);
      else begin
        e = expq.pop_front();
        chk("dout_ch", {30'd0, dch}, {30'd0, e.ch});
        chk("dout_a", {16'd0, douta}, {16'd0, e.a});
        chk("dout_b", {16'd0, doutb}, {16'd0, e.b});
      end
      last_a = douta;
    end else if (douta !== last_a) chk("dout_hold", {16'd0, douta}, {16'd0, last_a});
    if (fdone) n_done++;
    if (berr) n_berr++;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {25'd0, convst, cs_n, sclk, dvld, fbusy, fdone, berr}, 32'b0110000);
    chk({tag, "_da"}, {16'd0, douta}, 0);
    chk({tag, "_db"}, {16'd0, doutb}, 0);
    chk({tag, "_ch"}, {30'd0, dch}, 0);
  endtask

  task automatic fill(input logic rnd_b, input logic [DW-1:0] fixed_b);
    for (int c = 0; c < CHN; c++) begin
      word_a[c] = DW'($urandom);
      word_b[c] = rnd_b ? DW'($urandom) : fixed_b;
    end
  endtask

  task automatic push_exp(input logic mode, input int skip, input int first, input int last);
    for (int c = first; c <= last; c++)
      if (c != skip) expq.push_back('{ch: 2'(c), a: word_a[c], b: mode ? word_b[c] : '0});
  endtask

  task automatic run_frame(input logic mode, input int skip, input bit extra, input int exp_vld);
    bit got;
    skip_ch = skip; conv_cnt = 0; n_vld = 0; n_done = 0; n_berr = 0;
    push_exp(mode, skip, 0, CHN - 1);
    @(negedge gclk);
    chk("idle_fbusy", {31'd0, fbusy}, 0);
    lane_mode = mode; frm_start = 1;
    @(negedge gclk);
    frm_start = 0;
    chk("fbusy_rise", {31'd0, fbusy}, 1);
    got = 0;
    for (int cyc = 0; cyc < 5000 && !got; cyc++) begin
      @(negedge gclk);
      if (fdone) begin
        got = 1;
        chk("fbusy_at_done", {31'd0, fbusy}, 0);
      end else begin
        frm_start = extra && (cyc % 97 == 50);
        lane_mode = frm_start ? ~mode : mode;
      end
    end
    frm_start = 0; lane_mode = mode;
    chk("frm_done_seen", {31'd0, got}, 1);
    repeat (3) @(negedge gclk);
    chk("n_vld", n_vld, exp_vld);
    chk("n_done", n_done, 1);
    chk("n_berr", n_berr, (skip < CHN) ? 1 : 0);
    chk("expq_empty", expq.size(), 0);
    expq.delete();
  endtask

  initial begin
    bit got;
    int rises, per, last, cyc;
    logic prev;
    fill(1, '0);
    @(negedge gclk);
    chk_reset("rst");
    grst_n = 1;
    repeat (2) @(negedge gclk);

    // Fixed pattern, both lanes
    for (int c = 0; c < CHN; c++) begin word_a[c] = 16'hA5A5; word_b[c] = 16'h1234; end
    busy_len = 20;
    run_frame(1, 99, 0, 4);

    // Single lane: DOUT_B must read zero even with SDOB high
    fill(0, 16'hFFFF);
    run_frame(0, 99, 0, 4);

    // BUSY never rises on channel 2
    fill(1, '0);
    run_frame(1, 2, 0, 3);

    // Repeated FRM_START with flipped LANE_MODE mid-frame
    fill(1, '0);
    run_frame(1, 99, 1, 4);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      busy_len = $urandom_range(5, 40);
      fill(1, '0);
      run_frame(1'($urandom_range(0, 1)), 99, 0, 4);
    end

    // Reset during SHIFT of channel 1
    busy_len = 20; skip_ch = 99;
    fill(1, '0);
    conv_cnt = 0; n_vld = 0; n_done = 0;
    push_exp(1, 99, 0, 0);
    @(negedge gclk); lane_mode = 1; frm_start = 1;
    @(negedge gclk); frm_start = 0;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge gclk);
      if (conv_cnt == 2 && !cs_n && !sclk) got = 1;
    end
    chk("reach_shift_ch1", {31'd0, got}, 1);
    #2 grst_n = 0;
    @(negedge gclk);
    chk_reset("midrst");
    repeat (3) @(negedge gclk);
    grst_n = 1;
    repeat (60) @(negedge gclk);
    chk("midrst_no_done", n_done, 0);
    chk("midrst_n_vld", n_vld, 1);
    chk("midrst_expq", expq.size(), 0);
    expq.delete();
    fill(1, '0);
    run_frame(1, 99, 0, 4);

    // Wide sample, slower serial clock on the second instance
    @(negedge gclk); frm_start2 = 1;
    @(negedge gclk); frm_start2 = 0;
    got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge gclk);
      if (!cs2_n) got = 1;
    end
    chk("w_cs_low", {31'd0, got}, 1);
    rises = 0; per = -1; last = -1; cyc = 0; prev = sclk2; got = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge gclk);
      cyc++;
      if (dvld2) begin
        got = 1;
        chk("w_dout_a", {14'd0, douta2}, {14'd0, word2});
      end
      if (cs2_n) break;
      if (sclk2 && !prev) begin
        rises++;
        if (last >= 0) per = cyc - last;
        last = cyc;
      end
      prev = sclk2;
    end
    chk("w_rises", rises, DW2);
    chk("w_period", per, 6);
    chk("w_valid", {31'd0, got}, 1);
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge gclk);
      if (fdone2) got = 1;
    end
    chk("w_done", {31'd0, got}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ads_frame_rdout.md
ADS_FRAME_RDOUT -- requirements
Module: ads_frame_rdout

Interface
REQ-001 Parameter DATA_W, default 16, ADC sample width in bits.
REQ-002 Parameter CH_NUM, default 64, conversions per frame (one per AFE channel).
REQ-003 Parameter SCLK_DIV, default 2, ADS_CLK half-period in CLK_100M cycles (>=1).
REQ-004 Parameter CONV_HI, default 4, ADS_CONVST high width in CLK_100M cycles.
REQ-005 Parameter BUSY_TO, default 256, max CLK_100M cycles spent waiting for ADS_BUSY to complete.
REQ-006 Parameter CS_GAP, default 4, ADS_CS_N high cycles between conversions.
REQ-007 CLK_100M  in  1  sole clock; all logic on its rising edge.
REQ-008 CLK_RST  in  1  reset, asynchronous assert, active-low.
REQ-009 FRM_START  in  1  one-cycle pulse; starts a frame of CH_NUM conversions.
REQ-010 LANE_MODE  in  1  0 = SDOA only, 1 = SDOA and SDOB; sampled at FRM_START.
REQ-011 ADS_CONVST  out  1  conversion start to ADC.
REQ-012 ADS_BUSY  in  1  ADC converting, asynchronous.
REQ-013 ADS_CS_N  out  1  ADC chip select, active-low.
REQ-014 ADS_CLK  out  1  serial clock, idles high.
REQ-015 ADS_SDOA / ADS_SDOB  in  1 each  serial data lanes, MSB first.
REQ-016 DOUT_A / DOUT_B  out  DATA_W each  deserialised samples; DOUT_B zero when LANE_MODE=0.
REQ-017 DOUT_CH  out  clog2(CH_NUM)  channel index of current sample.
REQ-018 DOUT_VALID  out  1  one-cycle pulse, DOUT_* valid.
REQ-019 FRM_BUSY  out  1  high from cycle after accepted FRM_START until FRM_DONE.
REQ-020 FRM_DONE  out  1  one-cycle pulse at end of frame.
REQ-021 BUSY_ERR  out  1  one-cycle pulse on BUSY timeout.

Function
REQ-022 FSM states: IDLE, CONV, WAIT_BUSY, SHIFT, OUT, GAP, DONE.
REQ-023 IDLE: FRM_START=1 -> CONV, channel counter=0, lane mode latched; FRM_START while not IDLE ignored.
REQ-024 CONV: ADS_CONVST high exactly CONV_HI cycles, then WAIT_BUSY.
REQ-025 ADS_BUSY passes a 2-FF synchroniser; WAIT_BUSY waits synced BUSY rise then fall, then SHIFT with ADS_CS_N low.
REQ-026 WAIT_BUSY timeout counter >= BUSY_TO -> BUSY_ERR pulse, no DOUT_VALID for that channel, go to GAP.
REQ-027 SHIFT: ADS_CLK toggles every SCLK_DIV cycles, exactly DATA_W low-to-high transitions; SDO lanes sampled in the cycle ADS_CLK goes high, shifted MSB first.
REQ-028 OUT: DOUT_A/B/CH loaded, DOUT_VALID=1 for one cycle, one CLK_100M cycle after the last sample edge.
REQ-029 GAP: ADS_CS_N high CS_GAP cycles; counter==CH_NUM-1 -> DONE, else counter+1 -> CONV.
REQ-030 DONE: FRM_DONE=1 one cycle, FRM_BUSY falls same cycle, -> IDLE.
REQ-031 DOUT_* hold last value until next OUT; ADS_CLK returns high on leaving SHIFT.
REQ-032 Channel counter never exceeds CH_NUM-1; no wrap within a frame.

Reset
REQ-033 On CLK_RST low, immediately: state IDLE, ADS_CONVST=0, ADS_CS_N=1, ADS_CLK=1, DOUT_A/B/CH=0, DOUT_VALID=0, FRM_BUSY=0, FRM_DONE=0, BUSY_ERR=0, all counters and synchronisers 0.
REQ-034 Reset mid-frame aborts the frame without FRM_DONE; first FRM_START after release starts at channel 0.

Structure
REQ-035 Shared package ads_pkg holds FSM state encoding and default parameter constants.
REQ-036 Sub-module ads_shift_rx: one-lane DATA_W shift register with sample enable, instantiated twice.

Verification
REQ-037 CH_NUM=4, LANE_MODE=1, BUSY model 20 cycles, SDOA=0xA5A5, SDOB=0x1234 -> 4 DOUT_VALID, DOUT_CH 0..3, DOUT_A=0xA5A5, DOUT_B=0x1234, one FRM_DONE.
REQ-038 LANE_MODE=0, SDOB=0xFFFF -> DOUT_B=0x0000 on every valid.
REQ-039 BUSY held low on channel 2, BUSY_TO=256 -> BUSY_ERR once, only 3 DOUT_VALID (CH 0,1,3), FRM_DONE still pulses.
REQ-040 FRM_START repeated mid-frame -> ignored, exactly CH_NUM valids.
REQ-041 CLK_RST low during SHIFT of channel 1 -> all outputs at reset values next cycle, no FRM_DONE; new FRM_START restarts at DOUT_CH=0.
REQ-042 SCLK_DIV=3, DATA_W=18 -> ADS_CLK period 6 cycles, 18 rising edges per CS_N low window.
